// File: rtl/serial_pkg.sv
// Shared definitions for the bit-serial complement stages: FSM state encoding
// and the default frame width.
package serial_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_COPY = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_shift_collect.sv
// LSB-first serial-to-parallel collector: shifts accepted bits in at the MSB
// and flags the bit that completes a WIDTH-bit frame.
module serial_shift_collect
    import serial_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             restart_i,
    input  logic             bit_i,
    output logic [WIDTH-1:0] word_o,
    output logic             done_o
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    count_q, count_d;
    logic [CW-1:0]    count_eff;

    always_comb begin
        // A restarting bit is always bit 0 of a new frame, whatever was pending.
        count_eff = restart_i ? '0 : count_q;
        done_o    = en_i && (count_eff == LAST);
        word_o    = {bit_i, shift_q[WIDTH-1:1]};
        shift_d   = shift_q;
        count_d   = count_q;
        if (en_i) begin
            shift_d = word_o;
            count_d = done_o ? '0 : count_eff + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_q <= '0;
            count_q <= '0;
        end else begin
            shift_q <= shift_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/serial_twos_comp.sv
// Serial +1 stage: turns an LSB-first one's-complement stream into two's
// complement, emitting both a re-timed bit stream and the assembled word.
module serial_twos_comp
    import serial_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             in_first,
    output logic             bit_out,
    output logic             bit_valid,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    output logic             word_carry,
    output logic             frame_err
);

    state_t           state_q, state_d;
    logic             carry_q, carry_d;
    logic             bit_out_q, bit_out_d;
    logic             bit_valid_q, bit_valid_d;
    logic [WIDTH-1:0] word_out_q, word_out_d;
    logic             word_valid_q, word_valid_d;
    logic             word_carry_q, word_carry_d;
    logic             frame_err_q, frame_err_d;

    logic             start, accept, c_eff, out_b, next_c, done;
    logic [WIDTH-1:0] word_next;

    assign start  = in_valid && in_first;
    assign accept = in_valid && (in_first || (state_q != S_IDLE));
    assign c_eff  = start ? 1'b1 : carry_q;
    assign out_b  = in_bit ^ c_eff;
    assign next_c = in_bit & c_eff;

    serial_shift_collect #(.WIDTH(WIDTH)) u_collect (
        .clk      (clk),
        .rst      (rst),
        .en_i     (accept),
        .restart_i(start),
        .bit_i    (out_b),
        .word_o   (word_next),
        .done_o   (done)
    );

    always_comb begin
        state_d      = state_q;
        carry_d      = carry_q;
        bit_out_d    = bit_out_q;
        bit_valid_d  = 1'b0;
        word_out_d   = word_out_q;
        word_valid_d = 1'b0;
        word_carry_d = word_carry_q;
        // Stray continuation bit while idle, or a new LSB cutting a frame short.
        frame_err_d  = in_valid && (in_first ? (state_q != S_IDLE) : (state_q == S_IDLE));
        if (accept) begin
            bit_out_d   = out_b;
            bit_valid_d = 1'b1;
            if (done) begin
                state_d      = S_IDLE;
                carry_d      = 1'b1;
                word_out_d   = word_next;
                word_carry_d = next_c;
                word_valid_d = 1'b1;
            end else begin
                state_d = next_c ? S_ADD : S_COPY;
                carry_d = next_c;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            carry_q      <= 1'b1;
            bit_out_q    <= 1'b0;
            bit_valid_q  <= 1'b0;
            word_out_q   <= '0;
            word_valid_q <= 1'b0;
            word_carry_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            carry_q      <= carry_d;
            bit_out_q    <= bit_out_d;
            bit_valid_q  <= bit_valid_d;
            word_out_q   <= word_out_d;
            word_valid_q <= word_valid_d;
            word_carry_q <= word_carry_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign bit_out    = bit_out_q;
    assign bit_valid  = bit_valid_q;
    assign word_out   = word_out_q;
    assign word_valid = word_valid_q;
    assign word_carry = word_carry_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_serial_twos_comp.sv
// Bench for serial_twos_comp: directed scenarios plus random framing traffic,
// checked every cycle against an arithmetic model of the +1 on the frame value.
module tb_serial_twos_comp;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0, in_bit = 1'b0, in_first = 1'b0;
    logic         bit_out, bit_valid, word_valid, word_carry, frame_err;
    logic [W-1:0] word_out;

    int checks = 0;
    int failures = 0;

    // Model state: bits of the current frame as an integer value.
    bit           m_active;
    int           m_nbits;
    longint       m_acc;
    logic         e_bo, e_bv, e_wv, e_wc, e_fe;
    logic [W-1:0] e_wo;

    serial_twos_comp #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .in_first  (in_first),
        .bit_out   (bit_out),
        .bit_valid (bit_valid),
        .word_out  (word_out),
        .word_valid(word_valid),
        .word_carry(word_carry),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    function automatic logic [W+4:0] act_vec();
        return {bit_valid, bit_out, word_valid, word_out, word_carry, frame_err};
    endfunction

    function automatic logic [W+4:0] exp_vec();
        return {e_bv, e_bo, e_wv, e_wo, e_wc, e_fe};
    endfunction

    task automatic model_reset();
        m_active = 1'b0; m_nbits = 0; m_acc = 0;
        e_bo = 1'b0; e_bv = 1'b0; e_wv = 1'b0; e_wc = 1'b0; e_fe = 1'b0; e_wo = '0;
    endtask

    // Apply one cycle of input, clock it, and advance the model to what the
    // registered outputs should now show.
    task automatic drive(input logic v, input logic b, input logic f);
        longint r, mask;
        in_valid = v; in_bit = b; in_first = f;
        @(posedge clk); #1;
        e_bv = 1'b0; e_wv = 1'b0; e_fe = 1'b0;
        if (v) begin
            if (f) begin
                e_fe = m_active;
                m_active = 1'b1; m_nbits = 0; m_acc = 0;
            end else if (!m_active) begin
                e_fe = 1'b1;
            end
            if (m_active) begin
                m_acc = m_acc | (longint'(b) << m_nbits);
                m_nbits++;
                r    = m_acc + 1;
                mask = (longint'(1) << m_nbits) - 1;
                e_bo = ((r & mask) >> (m_nbits - 1)) & 1;
                e_bv = 1'b1;
                if (m_nbits == W) begin
                    e_wv = 1'b1;
                    e_wo = W'(r);
                    e_wc = r[W];
                    m_active = 1'b0; m_nbits = 0; m_acc = 0;
                end
            end
        end
    endtask

    task automatic test_reset();
        in_valid = 1'b0; in_bit = 1'b0; in_first = 1'b0;
        rst = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (act_vec() !== '0) begin
            failures++;
            $display("FAIL reset_hold: got %b required %b", act_vec(), {(W+5){1'b0}});
        end
        @(negedge clk); rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        checks++;
        if (act_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL reset_idle: got %b required %b", act_vec(), exp_vec());
        end
    endtask

    task automatic run_frame(input string name, input logic [W-1:0] bits, input int gap);
        for (int i = 0; i < W; i++) begin
            drive(1'b1, bits[i], i == 0);
            checks++;
            if (act_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL %s bit%0d: got %b required %b", name, i, act_vec(), exp_vec());
            end
            for (int g = 0; g < gap; g++) begin
                drive(1'b0, 1'b0, 1'b0);
                checks++;
                if (act_vec() !== exp_vec()) begin
                    failures++;
                    $display("FAIL %s gap%0d_%0d: got %b required %b", name, i, g, act_vec(), exp_vec());
                end
            end
        end
    endtask

    task automatic test_basic();
        run_frame("basic", 4'b1010, 0);
        checks++;
        if (word_out !== 4'b1011 || word_carry !== 1'b0 || word_valid !== 1'b1) begin
            failures++;
            $display("FAIL basic_word: got wo=%b wc=%b wv=%b required wo=1011 wc=0 wv=1",
                     word_out, word_carry, word_valid);
        end
        drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_all_ones();
        run_frame("ones", 4'b1111, 0);
        checks++;
        if (word_out !== 4'b0000 || word_carry !== 1'b1) begin
            failures++;
            $display("FAIL ones_word: got wo=%b wc=%b required wo=0000 wc=1", word_out, word_carry);
        end
        drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_gaps();
        run_frame("gaps", 4'b1101, 3);
        drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_frame("b2b_a", 4'b0000, 0);
        run_frame("b2b_b", 4'b1110, 0);
        checks++;
        if (word_out !== 4'b1111 || word_valid !== 1'b1 || frame_err !== 1'b0) begin
            failures++;
            $display("FAIL b2b_word: got wo=%b wv=%b fe=%b required wo=1111 wv=1 fe=0",
                     word_out, word_valid, frame_err);
        end
        drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_violations();
        logic [2:0] pre;
        pre = 3'b011;
        // Abort after two bits: third bit carries in_first.
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, pre[i], i == 0);
            checks++;
            if (act_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL abort_pre%0d: got %b required %b", i, act_vec(), exp_vec());
            end
        end
        run_frame("abort_new", 4'b0110, 0);
        drive(1'b0, 1'b0, 1'b0);
        // Continuation bit while idle must be dropped with an error.
        drive(1'b1, 1'b1, 1'b0);
        checks++;
        if (act_vec() !== exp_vec() || frame_err !== 1'b1 || bit_valid !== 1'b0) begin
            failures++;
            $display("FAIL idle_drop: got %b required %b", act_vec(), exp_vec());
        end
        drive(1'b0, 1'b0, 1'b0);
        checks++;
        if (act_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL idle_drop_after: got %b required %b", act_vec(), exp_vec());
        end
    endtask

    task automatic test_mid_reset();
        drive(1'b1, 1'b1, 1'b1);
        drive(1'b1, 1'b0, 1'b0);
        #2;
        rst = 1'b0; in_valid = 1'b0; in_bit = 1'b0; in_first = 1'b0;
        #1;
        checks++;
        if (act_vec() !== '0) begin
            failures++;
            $display("FAIL mid_reset_clear: got %b required %b", act_vec(), {(W+5){1'b0}});
        end
        model_reset();
        @(negedge clk); rst = 1'b1;
        run_frame("post_reset", 4'b0011, 0);
        drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        logic v, b, f;
        for (int c = 0; c < 400; c++) begin
            v = ($urandom_range(0, 9) > 2);
            b = 1'($urandom_range(0, 1));
            f = m_active ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 7) != 0);
            drive(v, b, f);
            checks++;
            if (act_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL random cyc%0d: got %b required %b", c, act_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_all_ones();
        test_gaps();
        test_back_to_back();
        test_violations();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
